instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 78 +++++++
 tb/tb_instruction_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: two-state fetch/issue sequencer; ATC words branch on sticky
// attention flags internally, all other words are issued to an external executor.
`ifndef ATC
`define ATC 3'b111
`endif

module instruction_fetch #(
    parameter logic [7:0] RESET_ADDR = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  attn_pulse,
    input  logic [31:0] instruction,
    input  logic        exec_done,
    input  logic        jump_taken,
    input  logic [7:0]  jump_addr,
    output logic [7:0]  address,
    output logic [31:0] instr_reg,
    output logic        instr_valid,
    output logic [7:0]  attn_flags
);
    typedef enum logic {FETCH, ISSUE} state_t;

    state_t      state, state_next;
    logic [2:0]  opcode, sub_op;
    logic [7:0]  target, pc_next, clear;
    logic        is_atc, atc_hit, done;

    assign opcode  = instruction[31:29];
    assign sub_op  = instruction[28:26];
    assign target  = instruction[7:0];
    assign is_atc  = enable && state == FETCH && opcode == `ATC;
    assign atc_hit = is_atc && attn_flags[sub_op];
    assign done    = enable && state == ISSUE && exec_done;
    assign clear   = atc_hit ? 8'd1 << sub_op : 8'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (enable && state == FETCH && opcode != `ATC)
            state_next = ISSUE;
        else if (done)
            state_next = FETCH;
    end

    always_comb begin
        instr_valid = state == ISSUE;
    end

    always_comb begin
        pc_next = address;
        if (is_atc)
            pc_next = atc_hit ? target : address + 8'd1;
        else if (done)
            pc_next = jump_taken ? jump_addr : address + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address    <= RESET_ADDR;
            instr_reg  <= 32'd0;
            attn_flags <= 8'd0;
        end else begin
            address <= pc_next;
            if (enable && state == FETCH)
                instr_reg <= instruction;
            // A coincident pulse wins over the ATC clear
            attn_flags <= (attn_flags & ~clear) | attn_pulse;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed corner cases plus randomized traffic checked
// against a behavioural model of the fetch/issue rules.
`ifndef ATC
`define ATC 3'b111
`endif

module tb_instruction_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  attn_pulse = 8'd0;
    logic [31:0] instruction;
    logic        exec_done = 1'b0;
    logic        jump_taken = 1'b0;
    logic [7:0]  jump_addr = 8'd0;
    logic [7:0]  address;
    logic [31:0] instr_reg;
    logic        instr_valid;
    logic [7:0]  attn_flags;

    logic [31:0] mem [256];
    logic [7:0]  m_pc;
    logic        m_issue;
    logic [31:0] m_ir;
    logic [7:0]  m_flags;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] ATC3_5   = {`ATC, 3'd3, 18'd0, 8'd5};

    instruction_fetch #(.RESET_ADDR(8'd0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .attn_pulse(attn_pulse),
        .instruction(instruction), .exec_done(exec_done), .jump_taken(jump_taken),
        .jump_addr(jump_addr), .address(address), .instr_reg(instr_reg),
        .instr_valid(instr_valid), .attn_flags(attn_flags)
    );

    assign instruction = mem[address];

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".address"}, {24'd0, address}, {24'd0, m_pc});
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, m_issue});
        chk({tag, ".ir"}, instr_reg, m_ir);
        chk({tag, ".flags"}, {24'd0, attn_flags}, {24'd0, m_flags});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_pc = 8'd0; m_issue = 1'b0; m_ir = 32'd0; m_flags = 8'd0;
        check_model("reset");
        #2;
        reset = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by the rules, compare after the edge
    task automatic step(input logic en, input logic [7:0] pulse, input logic dn,
                        input logic jt, input logic [7:0] ja, input string tag);
        logic [31:0] w;
        logic [7:0]  clr;
        enable = en; attn_pulse = pulse; exec_done = dn; jump_taken = jt; jump_addr = ja;
        w = mem[m_pc];
        clr = 8'd0;
        if (en) begin
            if (!m_issue) begin
                m_ir = w;
                if (w[31:29] == `ATC) begin
                    if (m_flags[w[28:26]]) begin
                        m_pc = w[7:0];
                        clr[w[28:26]] = 1'b1;
                    end else
                        m_pc = m_pc + 8'd1;
                end else
                    m_issue = 1'b1;
            end else if (dn) begin
                m_pc = jt ? ja : m_pc + 8'd1;
                m_issue = 1'b0;
            end
        end
        m_flags = (m_flags & ~clr) | pulse;
        @(posedge clock);
        #1;
        check_model(tag);
        attn_pulse = 8'd0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP_WORD;
        @(posedge clock);
        #1;
        apply_reset();

        // Plain word: fetch, one issue cycle, then advance
        step(1, 0, 0, 0, 0, "plain_fetch");
        chk("plain_fetch.valid_c", {31'd0, instr_valid}, 32'd1);
        chk("plain_fetch.addr_c", {24'd0, address}, 32'd0);
        step(1, 0, 1, 0, 0, "plain_done");
        chk("plain_done.addr_c", {24'd0, address}, 32'd1);
        chk("plain_done.valid_c", {31'd0, instr_valid}, 32'd0);

        // ATC with flag clear falls through
        mem[0] = ATC3_5;
        apply_reset();
        step(1, 0, 0, 0, 0, "atc_miss");
        chk("atc_miss.addr_c", {24'd0, address}, 32'd1);
        chk("atc_miss.valid_c", {31'd0, instr_valid}, 32'd0);

        // ATC with flag set jumps and clears
        apply_reset();
        step(0, 8'h08, 0, 0, 0, "pulse3");
        chk("pulse3.flags_c", {24'd0, attn_flags}, 32'h08);
        step(1, 0, 0, 0, 0, "atc_hit");
        chk("atc_hit.addr_c", {24'd0, address}, 32'd5);
        chk("atc_hit.flag_c", {31'd0, attn_flags[3]}, 32'd0);

        // Coincident pulse keeps the flag while the jump is still taken
        apply_reset();
        step(0, 8'h08, 0, 0, 0, "pulse3b");
        step(1, 8'h08, 0, 0, 0, "atc_set_prio");
        chk("atc_set_prio.addr_c", {24'd0, address}, 32'd5);
        chk("atc_set_prio.flag_c", {31'd0, attn_flags[3]}, 32'd1);

        // PC wrap and jump from ISSUE
        mem[0] = NOP_WORD;
        apply_reset();
        step(1, 0, 0, 0, 0, "w_fetch0");
        step(1, 0, 1, 1, 8'd255, "w_jump255");
        step(1, 0, 0, 0, 0, "w_fetch255");
        step(1, 0, 1, 0, 0, "w_wrap");
        chk("w_wrap.addr_c", {24'd0, address}, 32'd0);
        step(1, 0, 0, 0, 0, "w_fetch0b");
        step(1, 0, 1, 1, 8'd23, "w_jump23");
        chk("w_jump23.addr_c", {24'd0, address}, 32'd23);

        // Reset mid-ISSUE with enable low, then stray exec_done in FETCH
        mem[23] = NOP_WORD;
        step(1, 8'h41, 0, 0, 0, "r_fetch");
        step(0, 0, 0, 0, 0, "r_hold");
        apply_reset();
        chk("r_mid.addr_c", {24'd0, address}, 32'd0);
        chk("r_mid.valid_c", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 1, 1, 8'd77, "r_ignore_done");
        chk("r_ignore_done.addr_c", {24'd0, address}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 2) == 0) r[31:29] = `ATC;
            else if (r[31:29] == `ATC) r[31:29] = 3'd0;
            mem[i] = r;
        end
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] p;
            p = ($urandom_range(0, 3) == 0) ? 8'd1 << $urandom_range(0, 7) : 8'd0;
            if ($urandom_range(0, 199) == 0)
                apply_reset();
            else
                step($urandom_range(0, 3) != 0, p, 1'($urandom), 1'($urandom),
                     8'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
